// File: rtl/smbus_recovery_pkg.sv
// Shared types and constants for the SMBus stuck-bus recovery block.
package smbus_recovery_pkg;

  typedef enum logic [2:0] {
    MONITOR = 3'd0,
    ISOLATE = 3'd1,
    RECOVER = 3'd2,
    FAULT   = 3'd3,
    HOLDOFF = 3'd4
  } recState_t;

  // SCL pulses clocked out before declaring SDA permanently stuck
  localparam int RECOVERY_PULSE_COUNT = 9;

  // Flops in the pad synchroniser ahead of the stability counter
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/od_glitch_filter.sv
// Open-drain pad synchroniser plus stability filter. The output only moves
// after FILTER_CYCLES consecutive synchronised samples disagree with it.
module od_glitch_filter
  import smbus_recovery_pkg::*;
#(
  parameter int FILTER_CYCLES = 4
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iPad,
  output logic oFilt
);

  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);

  logic [SYNC_STAGES-1:0] syncQ;
  logic [CNT_W-1:0]       stableCnt;
  logic                   syncOut;

  assign syncOut = syncQ[SYNC_STAGES-1];

  // Synchronise the pad, then count consecutive samples that differ from the output
  always_ff @(posedge iClk) begin
    if (iRst) begin
      syncQ     <= '1;
      stableCnt <= '0;
      oFilt     <= 1'b1;
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], iPad};
      if (syncOut != oFilt) begin
        if (stableCnt == CNT_W'(FILTER_CYCLES - 1)) begin
          oFilt     <= syncOut;
          stableCnt <= '0;
        end else begin
          stableCnt <= stableCnt + 1'b1;
        end
      end else begin
        stableCnt <= '0;
      end
    end
  end

endmodule

// File: rtl/smbus_stuck_recovery.sv
// SMBus stuck-bus watchdog: filters SCL/SDA, isolates the buffers when SCL
// is held low past the timeout, optionally clocks SCL to free SDA, and
// re-enables the buffers after a bus-free holdoff.
// Optional feature: define SMBUS_RECOVERY_PULSES_EN to build the RECOVER
// state; without it a low SDA after isolation goes straight to FAULT.
//
// state   | meaning
// MONITOR | buffers enabled, timing filtered SCL low
// ISOLATE | buffers released, waiting for SCL to come back high
// RECOVER | clocking SCL pulses to free a device holding SDA
// FAULT   | SDA still low after recovery, waiting for idle bus
// HOLDOFF | bus idle, counting free time before re-enabling
module smbus_stuck_recovery
  import smbus_recovery_pkg::*;
#(
  parameter int FILTER_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES    = 500000,
  parameter int PULSE_HALF_CYCLES = 100,
  parameter int HOLDOFF_CYCLES    = 1000
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iScl,
  input  logic iSda,
  output logic oSclFilt,
  output logic oSdaFilt,
  output logic oIsolate,
  output logic oSclDrvLow,
  output logic oTimeoutEvt,
  output logic oSdaStuck
);

  localparam int LOW_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

  // The SDA sample at the end of a high phase must see the filtered line
  if (PULSE_HALF_CYCLES <= SYNC_STAGES + FILTER_CYCLES) begin : gBadPulse
    $error("PULSE_HALF_CYCLES must exceed SYNC_STAGES + FILTER_CYCLES");
  end
  // Entry into HOLDOFF already counts one bus-free cycle
  if (HOLDOFF_CYCLES < 2) begin : gBadHoldoff
    $error("HOLDOFF_CYCLES must be at least 2");
  end

  recState_t         state, nextState;
  logic [LOW_W-1:0]  lowCnt, lowCntNext;
  logic [HOLD_W-1:0] holdCnt, holdCntNext;
  logic              busFree;
  logic              isolateNext, timeoutNext, stuckNext;

`ifdef SMBUS_RECOVERY_PULSES_EN
  localparam int PULSE_W = $clog2(PULSE_HALF_CYCLES + 1);
  localparam int PCNT_W  = $clog2(RECOVERY_PULSE_COUNT + 1);

  logic [PULSE_W-1:0] phaseTmr, phaseTmrNext;
  logic [PCNT_W-1:0]  pulseCnt, pulseCntNext;
  logic               drvLowQ, drvLowNext;

  assign oSclDrvLow = drvLowQ;
`else
  assign oSclDrvLow = 1'b0;
`endif

  od_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) uSclFilter (
    .iClk  (iClk),
    .iRst  (iRst),
    .iPad  (iScl),
    .oFilt (oSclFilt)
  );

  od_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) uSdaFilter (
    .iClk  (iClk),
    .iRst  (iRst),
    .iPad  (iSda),
    .oFilt (oSdaFilt)
  );

  assign busFree = oSclFilt & oSdaFilt;

  // State, counters and registered outputs
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state       <= MONITOR;
      lowCnt      <= '0;
      holdCnt     <= '0;
      oIsolate    <= 1'b0;
      oTimeoutEvt <= 1'b0;
      oSdaStuck   <= 1'b0;
`ifdef SMBUS_RECOVERY_PULSES_EN
      phaseTmr    <= '0;
      pulseCnt    <= '0;
      drvLowQ     <= 1'b0;
`endif
    end else begin
      state       <= nextState;
      lowCnt      <= lowCntNext;
      holdCnt     <= holdCntNext;
      oIsolate    <= isolateNext;
      oTimeoutEvt <= timeoutNext;
      oSdaStuck   <= stuckNext;
`ifdef SMBUS_RECOVERY_PULSES_EN
      phaseTmr    <= phaseTmrNext;
      pulseCnt    <= pulseCntNext;
      drvLowQ     <= drvLowNext;
`endif
    end
  end

  // Next state and counter updates; counters clear whenever not in use
  always_comb begin
    nextState   = state;
    lowCntNext  = '0;
    holdCntNext = '0;
`ifdef SMBUS_RECOVERY_PULSES_EN
    phaseTmrNext = '0;
    pulseCntNext = '0;
`endif
    case (state)
      MONITOR: begin
        if (!oSclFilt) begin
          if (lowCnt >= LOW_W'(TIMEOUT_CYCLES - 1)) begin
            nextState = ISOLATE;
          end else begin
            lowCntNext = lowCnt + 1'b1;
          end
        end
      end
      ISOLATE: begin
        if (busFree) begin
          nextState   = HOLDOFF;
          holdCntNext = HOLD_W'(1);
        end else if (oSclFilt) begin
`ifdef SMBUS_RECOVERY_PULSES_EN
          nextState    = RECOVER;
          phaseTmrNext = PULSE_W'(PULSE_HALF_CYCLES - 1);
`else
          nextState = FAULT;
`endif
        end
      end
`ifdef SMBUS_RECOVERY_PULSES_EN
      RECOVER: begin
        pulseCntNext = pulseCnt;
        if (phaseTmr != '0) begin
          phaseTmrNext = phaseTmr - 1'b1;
        end else if (drvLowQ) begin
          phaseTmrNext = PULSE_W'(PULSE_HALF_CYCLES - 1);
        end else if (oSdaFilt) begin
          nextState    = HOLDOFF;
          pulseCntNext = '0;
          holdCntNext  = busFree ? HOLD_W'(1) : '0;
        end else if (pulseCnt == PCNT_W'(RECOVERY_PULSE_COUNT - 1)) begin
          nextState    = FAULT;
          pulseCntNext = '0;
        end else begin
          phaseTmrNext = PULSE_W'(PULSE_HALF_CYCLES - 1);
          pulseCntNext = pulseCnt + 1'b1;
        end
      end
`endif
      FAULT: begin
        if (busFree) begin
          nextState   = HOLDOFF;
          holdCntNext = HOLD_W'(1);
        end
      end
      HOLDOFF: begin
        if (busFree) begin
          if (holdCnt >= HOLD_W'(HOLDOFF_CYCLES - 1)) begin
            nextState = MONITOR;
          end else begin
            holdCntNext = holdCnt + 1'b1;
          end
        end
      end
      default: nextState = MONITOR;
    endcase
  end

  // Output values for the coming cycle, derived from the state being entered
  always_comb begin
    isolateNext = 1'b0;
    stuckNext   = 1'b0;
`ifdef SMBUS_RECOVERY_PULSES_EN
    drvLowNext  = 1'b0;
`endif
    case (nextState)
      ISOLATE, HOLDOFF: isolateNext = 1'b1;
      FAULT: begin
        isolateNext = 1'b1;
        stuckNext   = 1'b1;
      end
`ifdef SMBUS_RECOVERY_PULSES_EN
      RECOVER: begin
        isolateNext = 1'b1;
        if (state != RECOVER) begin
          drvLowNext = 1'b1;
        end else if (phaseTmr != '0) begin
          drvLowNext = drvLowQ;
        end else begin
          drvLowNext = !drvLowQ;
        end
      end
`endif
      default: ;
    endcase
    timeoutNext = (state == MONITOR) && (nextState == ISOLATE);
  end

endmodule
